ssram_burst_reader: RTL and testbench

SSRAM_BURST_READER -- requirements
Module: ssram_burst_reader

---
 rtl/ssram_burst_reader.sv | 158 +++++++++++++++
 tb/tb_ssram_burst_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ssram_burst_reader.sv
// Burst reader that streams consecutive SSRAM words, wrapping at the end of memory,
// through a 4-entry output FIFO. Reads are credit-limited so the FIFO never overflows.
module ssram_burst_reader #(
  parameter int bitwidth    = 32,
  parameter int nrOfEntries = 512,
  localparam int AW         = $clog2(nrOfEntries)
) (
  input  logic                clock,
  input  logic                nReset,
  input  logic                start,
  input  logic [AW-1:0]       startAddress,
  input  logic [AW:0]         burstLength,
  output logic [AW-1:0]       ramAddress,
  output logic                ramWriteEnable,
  input  logic [bitwidth-1:0] ramDataIn,
  output logic [bitwidth-1:0] streamData,
  output logic                streamValid,
  input  logic                streamReady,
  output logic                streamLast,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state;
  state_t              state_next;

  logic [AW-1:0]       addr_cnt;
  logic [AW:0]         remaining;
  logic                p1_valid;
  logic                p1_last;
  logic                p2_valid;
  logic                p2_last;
  logic                done_q;

  logic [bitwidth-1:0] fifo_data [4];
  logic                fifo_last [4];
  logic [1:0]          wr_ptr;
  logic [1:0]          rd_ptr;
  logic [2:0]          fifo_count;

  logic                issue;
  logic                issue_last;
  logic [AW-1:0]       issue_addr;
  logic [AW:0]         rem_base;
  logic [3:0]          occupancy;
  logic                credit_ok;
  logic                push;
  logic                pop;
  logic                final_pop;
  logic                zero_start;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(nrOfEntries - 1)) ? '0 : a + 1'b1;
  endfunction

  // Words already buffered plus reads still in the SSRAM pipeline must fit in the FIFO.
  assign occupancy  = {1'b0, fifo_count} + {3'b000, p1_valid} + {3'b000, p2_valid};
  assign credit_ok  = (occupancy < 4'd4);
  assign push       = p2_valid;
  assign pop        = streamValid & streamReady;
  assign final_pop  = pop & fifo_last[rd_ptr];
  assign zero_start = (state == IDLE) & start & (burstLength == '0);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The first read is issued on the accepting edge itself so data arrives two edges later.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = addr_cnt;
    rem_base   = remaining;
    case (state)
      IDLE: begin
        rem_base   = burstLength;
        issue_addr = startAddress;
        if (start && (burstLength != '0)) begin
          issue      = 1'b1;
          issue_last = (burstLength == (AW+1)'(1));
          state_next = issue_last ? DRAIN : READ;
        end
      end
      READ: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (remaining == (AW+1)'(1));
          if (issue_last) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (final_pop) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ramAddress <= '0;
      addr_cnt   <= '0;
      remaining  <= '0;
      p1_valid   <= 1'b0;
      p1_last    <= 1'b0;
      p2_valid   <= 1'b0;
      p2_last    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      done_q     <= 1'b0;
    end else begin
      if (issue) begin
        ramAddress <= issue_addr;
        addr_cnt   <= next_addr(issue_addr);
        remaining  <= rem_base - (AW+1)'(1);
      end
      p1_valid   <= issue;
      p1_last    <= issue_last;
      p2_valid   <= p1_valid;
      p2_last    <= p1_last;
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      fifo_count <= fifo_count + 3'(push) - 3'(pop);
      done_q     <= zero_start | ((state == DRAIN) & final_pop);
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= ramDataIn;
      fifo_last[wr_ptr] <= p2_last;
    end
  end

  assign ramWriteEnable = 1'b0;
  assign streamValid    = (fifo_count != '0);
  assign streamData     = fifo_data[rd_ptr];
  assign streamLast     = streamValid & fifo_last[rd_ptr];
  assign busy           = (state != IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_ssram_burst_reader.sv
// Self-checking bench: SSRAM model plus a queue-based reference of the expected word stream.
module tb_ssram_burst_reader;

  localparam int BW    = 32;
  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);

  logic          clock;
  logic          n_reset;
  logic          start;
  logic [AW-1:0] start_address;
  logic [AW:0]   burst_length;
  logic [AW-1:0] ram_address;
  logic          ram_write_enable;
  logic [BW-1:0] ram_data_in;
  logic [BW-1:0] stream_data;
  logic          stream_valid;
  logic          stream_ready;
  logic          stream_last;
  logic          busy;
  logic          done;

  logic [BW-1:0] mem [DEPTH];
  int            num_compared;
  int            num_mismatched;

  ssram_burst_reader #(.bitwidth(BW), .nrOfEntries(DEPTH)) dut (
    .clock          (clock),
    .nReset         (n_reset),
    .start          (start),
    .startAddress   (start_address),
    .burstLength    (burst_length),
    .ramAddress     (ram_address),
    .ramWriteEnable (ram_write_enable),
    .ramDataIn      (ram_data_in),
    .streamData     (stream_data),
    .streamValid    (stream_valid),
    .streamReady    (stream_ready),
    .streamLast     (stream_last),
    .busy           (busy),
    .done           (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous SSRAM: data for an address appears one cycle after it is presented.
  always @(posedge clock) ram_data_in <= mem[ram_address];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_compared++;
    assert (observed === expected) else begin
      num_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic ready_at(input int mode, input int idx);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((idx % 4) == 0) || ((idx % 4) == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one burst and scores every transfer against mem[(addr+i) mod DEPTH].
  task automatic applyStimulus(input int addr, input int len, input int ready_mode,
                               input bit check_timing, input int inject_cyc, input int abort_after);
    logic [BW-1:0] exp_q[$];
    int  xfers;
    int  first_xfer;
    int  last_xfer;
    bit  last_pending;
    bit  finished;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(addr + i) % DEPTH]);
    xfers = 0; first_xfer = -1; last_xfer = -1; last_pending = 0; finished = 0;
    @(posedge clock); #1;
    start         = 1'b1;
    start_address = AW'(addr);
    burst_length  = (AW+1)'(len);
    stream_ready  = ready_at(ready_mode, 0);
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (cyc == inject_cyc) begin
        start         = 1'b1;
        start_address = AW'(addr + 100);
        burst_length  = (AW+1)'(5);
      end
      if (abort_after >= 0 && xfers == abort_after) begin
        n_reset = 1'b0;
        #1;
        checkOutput("rst_ram_address", ram_address, 0);
        checkOutput("rst_stream_valid", stream_valid, 0);
        checkOutput("rst_stream_last", stream_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        #1 n_reset = 1'b1;
        finished = 1;
      end else begin
        stream_ready = ready_at(ready_mode, cyc + 1);
        if (check_timing && cyc < len) checkOutput("ram_address", ram_address, (addr + cyc) % DEPTH);
        if (check_timing && cyc == len) checkOutput("ram_address_hold", ram_address, (addr + len - 1) % DEPTH);
        @(negedge clock);
        if (check_timing && cyc == 1) checkOutput("valid_latency_early", stream_valid, 0);
        if (check_timing && cyc == 2) checkOutput("valid_latency", stream_valid, 1);
        if (last_pending) begin
          checkOutput("done_pulse", done, 1);
          checkOutput("busy_after", busy, 0);
          checkOutput("valid_after", stream_valid, 0);
          finished = 1;
        end else begin
          checkOutput("busy_during", busy, 1);
          checkOutput("done_early", done, 0);
          if (stream_valid) begin
            if (exp_q.size() == 0) begin
              checkOutput("extra_word", stream_valid, 0);
            end else begin
              checkOutput("stream_data", stream_data, exp_q[0]);
              checkOutput("stream_last", stream_last, exp_q.size() == 1);
              if (stream_ready) begin
                void'(exp_q.pop_front());
                xfers++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
                if (exp_q.size() == 0) last_pending = 1;
              end
            end
          end
        end
      end
    end
    checkOutput("burst_finished", finished, 1);
    if (last_pending) begin
      @(negedge clock);
      checkOutput("done_single", done, 0);
    end
    if (ready_mode == 0 && abort_after < 0 && len > 0)
      checkOutput("throughput", last_xfer - first_xfer, len - 1);
    start = 1'b0;
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    n_reset        = 1'b0;
    start          = 1'b0;
    start_address  = '0;
    burst_length   = '0;
    stream_ready   = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_ram_address", ram_address, 0);
    checkOutput("reset_stream_valid", stream_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("write_enable", ram_write_enable, 0);
    #2 n_reset = 1'b1;

    $display("[TB] basic burst at 10");
    applyStimulus(10, 4, 0, 1, -1, -1);
    $display("[TB] wrapping burst at 510");
    applyStimulus(510, 4, 0, 1, -1, -1);
    $display("[TB] stalled burst");
    applyStimulus(200, 8, 1, 0, -1, -1);
    $display("[TB] single-word burst");
    applyStimulus(511, 1, 0, 1, -1, -1);

    $display("[TB] zero-length burst");
    @(posedge clock); #1;
    start        = 1'b1;
    burst_length = '0;
    @(posedge clock); #1;
    start = 1'b0;
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    checkOutput("zero_valid", stream_valid, 0);
    @(posedge clock); #1;
    checkOutput("zero_done_clear", done, 0);
    checkOutput("zero_valid_later", stream_valid, 0);
    checkOutput("zero_busy_later", busy, 0);

    $display("[TB] start during burst");
    applyStimulus(300, 8, 0, 1, 2, -1);

    $display("[TB] reset mid-burst");
    applyStimulus(40, 8, 0, 0, -1, 3);
    applyStimulus(0, 2, 0, 1, -1, -1);

    $display("[TB] random bursts");
    for (int k = 0; k < 8; k++) begin
      applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(1, 12), $urandom_range(0, 2), 0, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
